pairing_seq_ctrl: RTL
=====================

// Module: pairing_seq_ctrl
// PURPOSE
//  Microcoded sequencer for the pairing engine; parametrised successor of the fixed pairing top controller.
//  - Accepts a run request for one of 2**FUNC_W functions (Miller loop, final exp, Fp12 mul, ...).
//  - Walks microcode from an external ROM and issues datapath ops over a valid/ready channel.
//  - Loop branches are driven by the bits of the curve loop parameter.
//  - Reports busy/opstart/endflag to the host.
// PARAMETERS
//  FUNC_W      4                      function-select width
//  PC_W        10                     microcode address width
//  ENTRY_SHIFT 6                      function entry address = n_func << ENTRY_SHIFT
//  INST_W      32                     microcode word width
//  LOOP_BITS   64                     significant bits of loop parameter
//  LOOP_PARAM  64'hd201000000010000   loop parameter (BLS12-381 |x|)
// PORTS
//  clk        in   1            clock
//  rst        in   1            synchronous active-high reset
//  swrst      in   1            synchronous soft reset, same effect as rst
//  run        in   1            start request (level sampled in IDLE)
//  n_func     in   FUNC_W       function select, latched on accepted run
//  rom_rd     out  1            ROM read strobe
//  rom_addr   out  PC_W         ROM address (= pc)
//  rom_data   in   INST_W       ROM data, valid 1 cycle after rom_rd
//  op_valid   out  1            datapath op valid
//  op_data    out  INST_W-3     op payload (instruction bits [INST_W-4:0])
//  op_ready   in   1            datapath accepts op
//  opstart    out  1            1-cycle pulse on each accepted op (op_valid & op_ready)
//  busy       out  1            high from run accept to endflag, inclusive
//  endflag    out  1            1-cycle pulse on END
//  err        out  1            sticky illegal-opcode flag, cleared on next run accept
// BEHAVIOUR
//  Reset/swrst: state=IDLE, pc=0, bit_idx=LOOP_BITS-2; all outputs 0, including err.
//  Instruction word:
//   - opc = rom_data[INST_W-1:INST_W-3]
//   - tgt = rom_data[PC_W-1:0]
//   - opc values: 000 OP; 001 JBIT; 010 LDEC; 011 END; others illegal.
//  FSM states IDLE, FETCH, DECODE, ISSUE, DONE.
//   IDLE
//    - On run=1: pc<=n_func<<ENTRY_SHIFT, bit_idx<=LOOP_BITS-2, err<=0, busy<=1, go to FETCH.
//   FETCH
//    - rom_rd=1, rom_addr=pc, go to DECODE.
//   DECODE
//    - OP: latch payload, go to ISSUE.
//    - JBIT: pc<=LOOP_PARAM[bit_idx] ? tgt : pc+1, go to FETCH.
//    - LDEC at bit_idx=0: pc<=pc+1, go to FETCH.
//    - LDEC at bit_idx>0: bit_idx<=bit_idx-1, pc<=tgt, go to FETCH.
//    - END: go to DONE.
//    - Illegal opcode: err<=1, go to DONE.
//   ISSUE
//    - op_valid=1 with op_data held stable until op_ready.
//    - On handshake: opstart=1 (same cycle), pc<=pc+1, go to FETCH.
//   DONE
//    - endflag=1 for one cycle, busy<=0, go to IDLE.
//  Latency: run accept -> first op_valid = 3 cycles (FETCH, DECODE, ISSUE).
//   Each non-stalled op costs 3 cycles; each branch costs 2 cycles.
//  pc wraps modulo 2**PC_W with no error; bit_idx never underflows.
//  run while busy: ignored, n_func not re-latched.
//  run held high at DONE: new run accepted in the following IDLE cycle.
//  rst/swrst mid-operation: abort immediately.
//   - op_valid drops with no handshake completed.
//   - No endflag for the aborted run.
//  rst and swrst asserted together: identical to either alone.
//  op_ready high outside ISSUE: ignored.
// CONFIGURATION
//  PAIRING_SEQ_PERF_EN
//   - Defined: extra outputs cyc_cnt (32b) and op_cnt (16b).
//     - Both clear on run accept.
//     - cyc_cnt counts every busy cycle; op_cnt counts opstart pulses.
//     - Both saturate at all-ones and hold after endflag until next run accept.
//     - Both 0 on reset.
//   - Undefined: ports and counters absent; behaviour otherwise identical.
// TESTING
//  1. Reset, then idle: run=0 for 10 cycles -> busy=0, rom_rd=0, op_valid=0, endflag=0.
//  2. n_func=2, ROM[128]=OP(0x5A), ROM[129]=END, op_ready=1 ->
//     rom_addr 128 then 129; op_data=0x5A 3 cycles after run;
//     one opstart; endflag 6 cycles after run; busy low next cycle.
//  3. Same program, op_ready=0 for 5 cycles ->
//     op_valid and op_data stable for 6 cycles; single opstart on the ready cycle.
//  4. Loop: ROM[0]=OP, ROM[1]=LDEC tgt 0, ROM[2]=END, LOOP_BITS=4 ->
//     exactly 3 opstart pulses, then endflag; with PAIRING_SEQ_PERF_EN, op_cnt=3.
//  5. JBIT tgt 10 at ROM[0] with LOOP_PARAM=64'hd201000000010000, LOOP_BITS=64 ->
//     bit 62 is 1, so next rom_addr=10; with bit clear (LOOP_PARAM=0), next rom_addr=1.
//  6. Illegal opcode 111 at entry -> err=1, endflag pulse.
//     Second run while busy ignored; swrst during ISSUE -> IDLE next cycle, no endflag, err cleared.

Source files
------------

// File: rtl/pairing_seq_ctrl.sv
// Microcoded pairing sequencer: fetches from an external ROM, issues ops, loops on the curve parameter bits.
// Latency: run -> first op_valid 3 cycles; op 3 cycles, branch 2. Backpressure: ISSUE holds op until op_ready.
// Optional cycle/op performance counters with PAIRING_SEQ_PERF_EN.
module pairing_seq_ctrl #(
   parameter int          FUNC_W      = 4,
   parameter int          PC_W        = 10,
   parameter int          ENTRY_SHIFT = 6,
   parameter int          INST_W      = 32,
   parameter int          LOOP_BITS   = 64,
   parameter logic [63:0] LOOP_PARAM  = 64'hd201000000010000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              swrst,
   input  logic              run,
   input  logic [FUNC_W-1:0] n_func,
   output logic              rom_rd,
   output logic [PC_W-1:0]   rom_addr,
   input  logic [INST_W-1:0] rom_data,
   output logic              op_valid,
   output logic [INST_W-4:0] op_data,
   input  logic              op_ready,
   output logic              opstart,
   output logic              busy,
   output logic              endflag,
   output logic              err
`ifdef PAIRING_SEQ_PERF_EN
   ,
   output logic [31:0]       cyc_cnt,
   output logic [15:0]       op_cnt
`endif
);

   localparam int BI_W = (LOOP_BITS > 1) ? $clog2(LOOP_BITS) : 1;
   localparam logic [BI_W-1:0]      BI_INIT = BI_W'(LOOP_BITS - 2);
   localparam logic [BI_W-1:0]      BI_ONE  = 1;
   localparam logic [PC_W-1:0]      PC_ONE  = 1;
   localparam logic [LOOP_BITS-1:0] LP      = LOOP_PARAM[LOOP_BITS-1:0];

   localparam logic [2:0] OPC_OP   = 3'b000;
   localparam logic [2:0] OPC_JBIT = 3'b001;
   localparam logic [2:0] OPC_LDEC = 3'b010;
   localparam logic [2:0] OPC_END  = 3'b011;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_ISSUE, S_DONE} state_t;

   state_t              state, state_nxt;
   logic [PC_W-1:0]     pc, pc_nxt;
   logic [BI_W-1:0]     bit_idx, bit_nxt;
   logic [INST_W-4:0]   payload, pay_nxt;
   logic                err_nxt;

   logic [2:0]          opc;
   logic [PC_W-1:0]     tgt;
   logic [PC_W-1:0]     entry;

   assign opc   = rom_data[INST_W-1:INST_W-3];
   assign tgt   = rom_data[PC_W-1:0];
   assign entry = PC_W'(n_func) << ENTRY_SHIFT;

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      bit_nxt   = bit_idx;
      pay_nxt   = payload;
      err_nxt   = err;
      case (state)
         S_IDLE: begin
            if (run) begin
               state_nxt = S_FETCH;
               pc_nxt    = entry;
               bit_nxt   = BI_INIT;
               err_nxt   = 1'b0;
            end
         end
         S_FETCH: state_nxt = S_DECODE;
         S_DECODE: begin
            // rom_data is the word addressed during FETCH
            case (opc)
               OPC_OP: begin
                  pay_nxt   = rom_data[INST_W-4:0];
                  state_nxt = S_ISSUE;
               end
               OPC_JBIT: begin
                  pc_nxt    = LP[bit_idx] ? tgt : pc + PC_ONE;
                  state_nxt = S_FETCH;
               end
               OPC_LDEC: begin
                  if (bit_idx == '0) begin
                     pc_nxt = pc + PC_ONE;
                  end else begin
                     bit_nxt = bit_idx - BI_ONE;
                     pc_nxt  = tgt;
                  end
                  state_nxt = S_FETCH;
               end
               OPC_END: state_nxt = S_DONE;
               default: begin
                  err_nxt   = 1'b1;
                  state_nxt = S_DONE;
               end
            endcase
         end
         S_ISSUE: begin
            if (op_ready) begin
               pc_nxt    = pc + PC_ONE;
               state_nxt = S_FETCH;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || swrst) begin
         state   <= S_IDLE;
         pc      <= '0;
         bit_idx <= BI_INIT;
         payload <= '0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         bit_idx <= bit_nxt;
         payload <= pay_nxt;
         err     <= err_nxt;
      end
   end

   assign rom_rd   = (state == S_FETCH);
   assign rom_addr = pc;
   assign op_valid = (state == S_ISSUE);
   assign op_data  = payload;
   assign opstart  = op_valid & op_ready;
   assign busy     = (state != S_IDLE);
   assign endflag  = (state == S_DONE);

`ifdef PAIRING_SEQ_PERF_EN
   // Counters saturate and stay frozen in IDLE until the next run accept.
   always_ff @(posedge clk) begin
      if (rst || swrst) begin
         cyc_cnt <= '0;
         op_cnt  <= '0;
      end else if (state == S_IDLE && run) begin
         cyc_cnt <= '0;
         op_cnt  <= '0;
      end else begin
         if (busy && cyc_cnt != '1) cyc_cnt <= cyc_cnt + 32'd1;
         if (opstart && op_cnt != '1) op_cnt <= op_cnt + 16'd1;
      end
   end
`endif

endmodule
